// File: rtl/gi_aes_pkg.sv
// Shared AES-128 decrypt definitions: FSM and counter encodings, the inverse S-box table,
// and byte/column/GF(2^8) helpers.
package gi_aes_pkg;

    localparam int unsigned AES_NB = 4;
    localparam int unsigned AES_NR = 10;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRound = 2'd1,
        StFinal = 2'd2,
        StDone  = 2'd3
    } aesd_state_e;

    typedef logic [1:0] col_t;
    typedef logic [3:0] rnd_t;

    // Entry b occupies bits [2047-8b -: 8].
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b111} -: 8];
    endfunction

    // Column c of a block sits at [127-32c -: 32]; {~c, 5'b11111} is that base.
    function automatic logic [31:0] get_col(input logic [127:0] blk, input col_t c);
        return blk[{~c, 5'b11111} -: 32];
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] col, input col_t r);
        return col[{~r, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/gi_isbox.sv
// Combinational 8-bit AES inverse S-box.
module gi_isbox
    import gi_aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = inv_sbox(i_byte);

endmodule

// File: rtl/gi_mixd.sv
// AES InvMixColumns on a single 32-bit column (row 0 in bits [31:24]).
module gi_mixd
    import gi_aes_pkg::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    logic [7:0] w_m9 [4];
    logic [7:0] w_mb [4];
    logic [7:0] w_md [4];
    logic [7:0] w_me [4];

    for (genvar r = 0; r < 4; r++) begin : g_mul
        logic [7:0] w_a;
        logic [7:0] w_x2;
        logic [7:0] w_x4;
        logic [7:0] w_x8;
        assign w_a     = i_col[31-8*r -: 8];
        assign w_x2    = xtime(w_a);
        assign w_x4    = xtime(w_x2);
        assign w_x8    = xtime(w_x4);
        assign w_m9[r] = w_x8 ^ w_a;
        assign w_mb[r] = w_x8 ^ w_x2 ^ w_a;
        assign w_md[r] = w_x8 ^ w_x4 ^ w_a;
        assign w_me[r] = w_x8 ^ w_x4 ^ w_x2;
    end

    // Row r = 0e*a[r] ^ 0b*a[r+1] ^ 0d*a[r+2] ^ 09*a[r+3] (indices mod 4).
    for (genvar r = 0; r < 4; r++) begin : g_out
        assign o_col[31-8*r -: 8] = w_me[r] ^ w_mb[(r+1)%4] ^ w_md[(r+2)%4] ^ w_m9[(r+3)%4];
    end

endmodule

// File: rtl/gi_aesd_round.sv
// Column-serial AES-128 inverse cipher: one 32-bit column per cycle, 41-cycle latency.
// Define GI_AESD_CBC_EN to add CBC chaining (iv_ld/iv ports and a chain register).
module gi_aesd_round
    import gi_aes_pkg::*;
#(
    parameter int unsigned NROUNDS   = AES_NR,
    parameter bit          RESET_OUT = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [127:0] in_data,
    output logic [3:0]   key_idx,
    input  logic [127:0] key_word,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [127:0] out_data,
`ifdef GI_AESD_CBC_EN
    input  logic         iv_ld,
    input  logic [127:0] iv,
`endif
    output logic         busy
);

    aesd_state_e  r_state;
    aesd_state_e  w_state_d;
    col_t         r_col;
    rnd_t         r_rnd;
    logic [127:0] r_st;
    logic [127:0] r_nxt;
    logic [127:0] r_out;
    logic [31:0]  w_shift_col;
    logic [31:0]  w_sub_col;
    logic [31:0]  w_ark;
    logic [31:0]  w_mix;
    logic [31:0]  w_res;
    logic [127:0] w_blk;
    logic [127:0] w_out_val;
    logic         w_accept;
    logic         w_col_act;
    logic         w_out_ld;

    // InvShiftRows: row r of column c comes from old column (c - r) mod 4.
    for (genvar r = 0; r < AES_NB; r++) begin : g_row
        col_t w_src;
        assign w_src = col_t'(r_col - col_t'(r));
        assign w_shift_col[31-8*r -: 8] = get_byte(get_col(r_st, w_src), col_t'(r));
        gi_isbox u_isbox (
            .i_byte (w_shift_col[31-8*r -: 8]),
            .o_byte (w_sub_col[31-8*r -: 8])
        );
    end

    assign w_ark = w_sub_col ^ get_col(key_word, r_col);

    gi_mixd u_mixd (
        .i_col (w_ark),
        .o_col (w_mix)
    );

    assign w_res     = (r_state == StRound) ? w_mix : w_ark;
    assign w_blk     = {r_nxt[127:32], w_res};
    assign w_accept  = in_vld & in_rdy;
    assign w_col_act = (r_state == StRound) || (r_state == StFinal);
    assign w_out_ld  = (r_state == StFinal) && (r_col == 2'd3);

    always_comb begin
        w_state_d = r_state;
        in_rdy    = 1'b0;
        out_vld   = 1'b0;
        busy      = 1'b1;
        key_idx   = 4'(NROUNDS);
        unique case (r_state)
            StIdle: begin
                in_rdy = 1'b1;
                busy   = 1'b0;
                if (in_vld) w_state_d = StRound;
            end
            StRound: begin
                key_idx = r_rnd;
                if (r_col == 2'd3 && r_rnd == 4'd1) w_state_d = StFinal;
            end
            StFinal: begin
                key_idx = 4'd0;
                if (r_col == 2'd3) w_state_d = StDone;
            end
            StDone: begin
                out_vld = 1'b1;
                if (out_rdy) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_col   <= 2'd0;
            r_rnd   <= 4'(NROUNDS - 1);
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_col <= 2'd0;
                r_rnd <= 4'(NROUNDS - 1);
            end else if (w_col_act) begin
                r_col <= r_col + 2'd1;
                if (r_col == 2'd3 && r_rnd != 4'd0) r_rnd <= r_rnd - 4'd1;
            end
        end
    end

    // Round state and the partially built next state need no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_st <= in_data ^ key_word;
        end else if (r_state == StRound && r_col == 2'd3) begin
            r_st <= w_blk;
        end
        if (w_col_act) begin
            r_nxt[{~r_col, 5'b11111} -: 32] <= w_res;
        end
    end

`ifdef GI_AESD_CBC_EN
    logic [127:0] r_chain;
    logic [127:0] r_ct;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_chain <= '0;
        end else if (r_state == StIdle && iv_ld) begin
            r_chain <= iv;
        end else if (w_out_ld) begin
            r_chain <= r_ct;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_ct <= in_data;
    end

    assign w_out_val = w_blk ^ r_chain;
`else
    assign w_out_val = w_blk;
`endif

    if (RESET_OUT) begin : g_out_rst
        always_ff @(posedge clk) begin
            if (reset) begin
                r_out <= '0;
            end else if (w_out_ld) begin
                r_out <= w_out_val;
            end
        end
    end else begin : g_out_norst
        always_ff @(posedge clk) begin
            if (w_out_ld && !reset) r_out <= w_out_val;
        end
    end

    assign out_data = r_out;

endmodule

// File: tb/tb_gi_aesd_round.sv
// Directed bench for gi_aesd_round using FIPS-197 and SP800-38A vectors.
// Defining GI_AESD_CBC_EN also runs the CBC chain vectors.
`timescale 1ns/1ps
module tb_gi_aesd_round;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_vld;
    logic         in_rdy;
    logic [127:0] in_data;
    logic [3:0]   key_idx;
    logic [127:0] key_word;
    logic         out_vld;
    logic         out_rdy;
    logic [127:0] out_data;
    logic         busy;
`ifdef GI_AESD_CBC_EN
    logic         iv_ld;
    logic [127:0] iv;
`endif

    logic [127:0] keys [2][11];
    logic         key_set;
    logic [127:0] ecb_ct [4];
    logic [127:0] ecb_pt [4];
    logic [127:0] m_chain;
    logic [127:0] hold_exp;
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign key_word = (key_idx <= 4'd10) ? keys[key_set][key_idx] : '0;

    gi_aesd_round u_dut (
        .clk      (clk),
        .reset    (reset),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .key_idx  (key_idx),
        .key_word (key_word),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
`ifdef GI_AESD_CBC_EN
        .iv_ld    (iv_ld),
        .iv       (iv),
`endif
        .busy     (busy)
    );

    // In CBC builds every output is XORed with the previous ciphertext (0 after reset).
    function automatic logic [127:0] exp_pt(input logic [127:0] pt);
`ifdef GI_AESD_CBC_EN
        return pt ^ m_chain;
`else
        return pt;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_block(input logic [127:0] ct, output bit ok);
        in_vld  = 1'b1;
        in_data = ct;
        ok      = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (in_rdy) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_vld = 1'b0;
    endtask

    // Latency counts the accept cycle as cycle 1.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_vld && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_in_rdy: got %b want 1", in_rdy); end
        n_tests++;
        if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rst_out_vld: got %b want 0", out_vld); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_tests++;
        if (key_idx !== 4'd10) begin n_fail++; $display("FAIL rst_key_idx: got %0d want 10", key_idx); end
        n_tests++;
        if (out_data !== 128'h0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    endtask

    task automatic test_fips();
        bit ok;
        int lat;
        key_set = 1'b0;
        out_rdy = 1'b0;
        hold_exp = exp_pt(128'h00112233445566778899aabbccddeeff);
        accept_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, ok);
        n_tests++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL fips_accept: got %b want 1", ok); end
        wait_out(lat);
        n_tests++;
        if (lat != 41) begin n_fail++; $display("FAIL fips_latency: got %0d want 41", lat); end
        n_tests++;
        if (out_vld !== 1'b1) begin n_fail++; $display("FAIL fips_out_vld: got %b want 1", out_vld); end
        n_tests++;
        if (out_data !== hold_exp) begin
            n_fail++; $display("FAIL fips_data: got %h want %h", out_data, hold_exp);
        end
        m_chain = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 20; i++) begin
            tick();
            n_tests++;
            if ({out_vld, in_rdy, out_data} !== {1'b1, 1'b0, hold_exp}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b %h want vld=1 rdy=0 %h",
                         i, out_vld, in_rdy, out_data, hold_exp);
            end
        end
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        n_tests++;
        if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_release_rdy: got %b want 1", in_rdy); end
        n_tests++;
        if (out_vld !== 1'b0) begin n_fail++; $display("FAIL bp_release_vld: got %b want 0", out_vld); end
    endtask

    task automatic test_back_to_back();
        int t_prev;
        int to;
        bit seq_bad;
        logic [3:0] want;
        logic [127:0] exp;
        key_set = 1'b1;
        out_rdy = 1'b1;
        t_prev  = 0;
        for (int b = 0; b < 4; b++) begin
            in_vld  = 1'b1;
            in_data = ecb_ct[b];
            to = 0;
            while (!in_rdy && to < 100) begin
                tick();
                to++;
            end
            n_tests++;
            if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy[%0d]: got %b want 1", b, in_rdy); end
            if (b > 0) begin
                n_tests++;
                if (cyc - t_prev != 42) begin
                    n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want 42", b, cyc - t_prev);
                end
            end
            t_prev  = cyc;
            exp     = exp_pt(ecb_pt[b]);
            seq_bad = (key_idx !== 4'd10);
            for (int j = 1; j <= 40; j++) begin
                tick();
                want = (j <= 36) ? 4'(9 - (j - 1) / 4) : 4'd0;
                if (key_idx !== want) seq_bad = 1'b1;
            end
            n_tests++;
            if (seq_bad) begin n_fail++; $display("FAIL b2b_key_seq[%0d]: got bad want good", b); end
            tick();
            n_tests++;
            if ({out_vld, out_data} !== {1'b1, exp}) begin
                n_fail++; $display("FAIL b2b_data[%0d]: got vld=%b %h want vld=1 %h", b, out_vld, out_data, exp);
            end
            m_chain = ecb_ct[b];
            if (b == 3) in_vld = 1'b0;
        end
        tick();
        out_rdy = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int lat;
        logic [127:0] exp;
        key_set = 1'b0;
        accept_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, ok);
        repeat (15) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_chain = '0;
        n_tests++;
        if ({in_rdy, out_vld, busy} !== 3'b100) begin
            n_fail++; $display("FAIL midrst_flags: got rdy/vld/busy=%b want 100", {in_rdy, out_vld, busy});
        end
        n_tests++;
        if (out_data !== 128'h0) begin n_fail++; $display("FAIL midrst_out_data: got %h want 0", out_data); end
        exp = exp_pt(128'h00112233445566778899aabbccddeeff);
        accept_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, ok);
        wait_out(lat);
        n_tests++;
        if (lat != 41) begin n_fail++; $display("FAIL midrst_latency: got %0d want 41", lat); end
        n_tests++;
        if (out_data !== exp) begin n_fail++; $display("FAIL midrst_data: got %h want %h", out_data, exp); end
        m_chain = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
    endtask

    task automatic test_busy_ignore();
        bit ok;
        bit rdy_seen;
        int lat;
        logic [127:0] exp;
        key_set  = 1'b1;
        rdy_seen = 1'b0;
        exp = exp_pt(ecb_pt[0]);
        accept_block(ecb_ct[0], ok);
        lat = 1;
        repeat (5) begin
            tick();
            lat++;
        end
        in_vld  = 1'b1;
        in_data = ecb_ct[1];
        while (!out_vld && lat < 200) begin
            if (in_rdy) rdy_seen = 1'b1;
            tick();
            lat++;
        end
        n_tests++;
        if (rdy_seen) begin n_fail++; $display("FAIL busy_rdy: got 1 want 0"); end
        n_tests++;
        if (lat != 41) begin n_fail++; $display("FAIL busy_latency: got %0d want 41", lat); end
        n_tests++;
        if (out_data !== exp) begin n_fail++; $display("FAIL busy_data: got %h want %h", out_data, exp); end
        in_vld  = 1'b0;
        m_chain = ecb_ct[0];
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        n_tests++;
        if ({in_rdy, busy} !== 2'b10) begin
            n_fail++; $display("FAIL busy_idle: got rdy/busy=%b want 10", {in_rdy, busy});
        end
    endtask

`ifdef GI_AESD_CBC_EN
    task automatic test_cbc();
        bit ok;
        int lat;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        key_set = 1'b1;
        iv_ld = 1'b1;
        iv    = 128'h000102030405060708090a0b0c0d0e0f;
        tick();
        iv_ld = 1'b0;
        accept_block(128'h7649abac8119b246cee98e9b12e9197d, ok);
        wait_out(lat);
        n_tests++;
        if (out_data !== 128'h6bc1bee22e409f96e93d7e117393172a) begin
            n_fail++; $display("FAIL cbc_blk1: got %h want 6bc1bee22e409f96e93d7e117393172a", out_data);
        end
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        accept_block(128'h5086cb9b507219ee95db113a917678b2, ok);
        // An IV load while busy must not disturb the chain.
        iv_ld = 1'b1;
        iv    = '1;
        tick();
        iv_ld = 1'b0;
        wait_out(lat);
        n_tests++;
        if (out_data !== 128'hae2d8a571e03ac9c9eb76fac45af8e51) begin
            n_fail++; $display("FAIL cbc_blk2: got %h want ae2d8a571e03ac9c9eb76fac45af8e51", out_data);
        end
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
    endtask
`endif

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        in_vld  = 1'b0;
        in_data = '0;
        out_rdy = 1'b0;
        key_set = 1'b0;
        m_chain = '0;
`ifdef GI_AESD_CBC_EN
        iv_ld = 1'b0;
        iv    = '0;
`endif
        keys[0][0]  = 128'h000102030405060708090a0b0c0d0e0f;
        keys[0][1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        keys[0][2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        keys[0][3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        keys[0][4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        keys[0][5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        keys[0][6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        keys[0][7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        keys[0][8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        keys[0][9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        keys[0][10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        keys[1][0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        keys[1][1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        keys[1][2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        keys[1][3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        keys[1][4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        keys[1][5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        keys[1][6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        keys[1][7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        keys[1][8]  = 128'head27321b58dbad2312bf5607f8d292f;
        keys[1][9]  = 128'hac7766f319fadc2128d12941575c006e;
        keys[1][10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        ecb_ct[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        ecb_pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
        ecb_ct[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
        ecb_pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        ecb_ct[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
        ecb_pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        ecb_ct[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;
        ecb_pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
        repeat (2) tick();
        reset = 1'b0;
        test_reset();
        test_fips();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_busy_ignore();
`ifdef GI_AESD_CBC_EN
        test_cbc();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
